// File: rtl/wram_bsram_arbiter.sv
// Arbitrates the single byte-wide WRAM BSRAM port between the NES CPU and the IOSys RISC-V core.
// RV word requests are broken into byte lanes; the CPU wins the port unless a WRAM load is ongoing.
module wram_bsram_arbiter #(
    parameter logic [21:0] CPU_WRAM_BASE = 22'h006000,
    parameter logic [22:0] RV_WRAM_BASE  = 23'h066000
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_wram_load_ongoing,
    input  logic [21:0] i_cpu_addr,
    input  logic        i_cpu_read,
    input  logic        i_cpu_write,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_hit,
    output logic [7:0]  o_cpu_drop_cnt,
    input  logic [22:0] i_rv_addr,
    input  logic        i_rv_word,
    input  logic [31:0] i_rv_wdata,
    input  logic [3:0]  i_rv_wstrb,
    input  logic        i_rv_req,
    output logic        o_rv_ack,
    output logic [15:0] o_rv_dout,
    output logic        o_rv_sel,
    output logic [12:0] o_bsram_addr,
    output logic        o_bsram_we,
    output logic [7:0]  o_bsram_din,
    input  logic [7:0]  i_bsram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN} state_t;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic        r_is_wr;
    logic        r_word;
    logic [1:0]  r_rd_idx;
    logic        r_cap_vld;
    logic        r_cap_hi;
    logic [15:0] r_rd_buf;
    logic        r_ack;
    logic [15:0] r_dout;
    logic [7:0]  r_cpu_rdata;
    logic        r_cpu_rd_pend;
    logic [7:0]  r_drop_cnt;

    logic        w_cpu_hit, w_rv_sel, w_rv_pending;
    logic        w_cpu_acc, w_cpu_grant, w_cpu_drop;
    logic        w_rv_want, w_rv_issue;
    logic [1:0]  w_wr_lane, w_rv_lane;
    logic [3:0]  w_mask_nxt;
    logic [7:0]  w_wr_byte;
    logic [12:0] w_bsram_addr;
    logic        w_bsram_we;
    logic [7:0]  w_bsram_din;

    assign w_cpu_hit    = (i_cpu_addr[21:13] == CPU_WRAM_BASE[21:13]);
    assign w_rv_sel     = (i_rv_addr[22:13] == RV_WRAM_BASE[22:13]);
    assign w_rv_pending = (i_rv_req != r_ack) & w_rv_sel;

    assign w_cpu_acc   = (i_cpu_read | i_cpu_write) & w_cpu_hit;
    assign w_cpu_grant = w_cpu_acc & ~i_wram_load_ongoing;
    assign w_cpu_drop  = w_cpu_acc & i_wram_load_ongoing;

    // A read keeps wanting the port until both lanes are issued; captures then drain on their own.
    assign w_rv_want  = (r_state == S_XFER) & (r_is_wr ? (r_mask != 4'd0) : (r_rd_idx != 2'd2));
    assign w_rv_issue = w_rv_want & ~w_cpu_grant;

    always_comb begin
        w_wr_lane = 2'd0;
        if (r_mask[0])      w_wr_lane = 2'd0;
        else if (r_mask[1]) w_wr_lane = 2'd1;
        else if (r_mask[2]) w_wr_lane = 2'd2;
        else if (r_mask[3]) w_wr_lane = 2'd3;
    end

    assign w_mask_nxt = r_mask & ~(4'b0001 << w_wr_lane);
    assign w_wr_byte  = r_wdata[{w_wr_lane, 3'b000} +: 8];
    assign w_rv_lane  = r_is_wr ? w_wr_lane : {r_word, r_rd_idx[0]};

    always_comb begin
        w_bsram_addr = 13'd0;
        w_bsram_we   = 1'b0;
        w_bsram_din  = 8'd0;
        if (i_resetn) begin
            if (w_cpu_grant) begin
                w_bsram_addr = i_cpu_addr[12:0];
                w_bsram_we   = i_cpu_write;
                w_bsram_din  = i_cpu_wdata;
            end else if (w_rv_issue) begin
                w_bsram_addr = {r_addr, w_rv_lane};
                w_bsram_we   = r_is_wr;
                w_bsram_din  = r_is_wr ? w_wr_byte : 8'd0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_rv_pending) w_state_nxt = S_XFER;
            S_XFER: begin
                if (r_is_wr) begin
                    if (w_rv_issue && (w_mask_nxt == 4'd0)) w_state_nxt = S_FIN;
                end else if (r_cap_vld && r_cap_hi) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state       <= S_IDLE;
            r_mask        <= 4'd0;
            r_is_wr       <= 1'b0;
            r_word        <= 1'b0;
            r_rd_idx      <= 2'd0;
            r_cap_vld     <= 1'b0;
            r_cap_hi      <= 1'b0;
            r_ack         <= 1'b0;
            r_dout        <= 16'd0;
            r_cpu_rdata   <= 8'd0;
            r_cpu_rd_pend <= 1'b0;
            r_drop_cnt    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_IDLE && w_rv_pending) begin
                r_mask   <= i_rv_wstrb;
                r_is_wr  <= (i_rv_wstrb != 4'd0);
                r_word   <= i_rv_word;
                r_rd_idx <= 2'd0;
            end else if (w_rv_issue) begin
                if (r_is_wr) r_mask   <= w_mask_nxt;
                else         r_rd_idx <= r_rd_idx + 2'd1;
            end

            // Each issued read lane is captured exactly one cycle later, stalled or not.
            r_cap_vld <= w_rv_issue & ~r_is_wr;
            r_cap_hi  <= r_rd_idx[0];

            if (r_state == S_FIN) begin
                r_ack <= ~r_ack;
                if (!r_is_wr) r_dout <= r_rd_buf;
            end

            r_cpu_rd_pend <= w_cpu_grant & i_cpu_read;
            if (r_cpu_rd_pend) r_cpu_rdata <= i_bsram_dout;

            if (w_cpu_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && w_rv_pending) begin
            r_addr  <= i_rv_addr[12:2];
            r_wdata <= i_rv_wdata;
        end
        if (r_cap_vld) begin
            if (r_cap_hi) r_rd_buf[15:8] <= i_bsram_dout;
            else          r_rd_buf[7:0]  <= i_bsram_dout;
        end
    end

    assign o_cpu_hit      = w_cpu_hit;
    assign o_cpu_rdata    = r_cpu_rdata;
    assign o_cpu_drop_cnt = r_drop_cnt;
    assign o_rv_sel       = w_rv_sel;
    assign o_rv_ack       = r_ack;
    assign o_rv_dout      = r_dout;
    assign o_bsram_addr   = w_bsram_addr;
    assign o_bsram_we     = w_bsram_we;
    assign o_bsram_din    = w_bsram_din;

endmodule

// File: tb/tb_wram_bsram_arbiter.sv
// Directed bench for wram_bsram_arbiter with a behavioural 8 kB synchronous BSRAM.
module tb_wram_bsram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        load;
    logic [21:0] cpu_addr;
    logic        cpu_read, cpu_write;
    logic [7:0]  cpu_wdata, cpu_rdata, drop_cnt;
    logic        cpu_hit;
    logic [22:0] rv_addr;
    logic        rv_word, rv_req, rv_ack, rv_sel;
    logic [31:0] rv_wdata;
    logic [3:0]  rv_wstrb;
    logic [15:0] rv_dout;
    logic [12:0] b_addr;
    logic        b_we;
    logic [7:0]  b_din, b_dout;

    logic [7:0]  mem [0:8191];
    logic [7:0]  wr4_log [$];
    int          we_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    wram_bsram_arbiter dut (
        .i_clk(clk), .i_resetn(resetn), .i_wram_load_ongoing(load),
        .i_cpu_addr(cpu_addr), .i_cpu_read(cpu_read), .i_cpu_write(cpu_write),
        .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_hit(cpu_hit),
        .o_cpu_drop_cnt(drop_cnt), .i_rv_addr(rv_addr), .i_rv_word(rv_word),
        .i_rv_wdata(rv_wdata), .i_rv_wstrb(rv_wstrb), .i_rv_req(rv_req),
        .o_rv_ack(rv_ack), .o_rv_dout(rv_dout), .o_rv_sel(rv_sel),
        .o_bsram_addr(b_addr), .o_bsram_we(b_we), .o_bsram_din(b_din),
        .i_bsram_dout(b_dout)
    );

    always @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_din;
            we_cnt <= we_cnt + 1;
            if (b_addr == 13'h004) wr4_log.push_back(b_din);
        end
        b_dout <= mem[b_addr];
    end

    task automatic run_rv(input logic [22:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic wrd, input int cpu_at, input logic [21:0] caddr,
                          input logic [7:0] cdata, output int edges);
        logic old_ack;
        int   k;
        old_ack  = rv_ack;
        rv_addr  = a;
        rv_wdata = wd;
        rv_wstrb = ws;
        rv_word  = wrd;
        rv_req   = ~rv_ack;
        edges    = -1;
        k        = 0;
        while (edges < 0 && k < 30) begin
            @(posedge clk); #1;
            k++;
            if (rv_ack != old_ack) edges = k;
            if (k == cpu_at) begin
                cpu_write = 1'b1;
                cpu_addr  = caddr;
                cpu_wdata = cdata;
            end else begin
                cpu_write = 1'b0;
            end
        end
        cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (rv_ack !== 1'b0)   begin n_fail++; $display("FAIL reset_ack got %0b want 0", rv_ack); end
        n_tests++; if (rv_dout !== 16'd0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", rv_dout); end
        n_tests++; if (cpu_rdata !== 8'd0) begin n_fail++; $display("FAIL reset_cpu_rdata got %h want 00", cpu_rdata); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        n_tests++; if ({b_we, b_addr, b_din} !== 22'd0) begin n_fail++; $display("FAIL reset_port got we=%b addr=%h din=%h want 0", b_we, b_addr, b_din); end
        resetn = 1'b1;
        n_tests++; if (cpu_hit !== 1'b1) begin n_fail++; $display("FAIL cpu_hit_6000 got %b want 1", cpu_hit); end
    endtask

    task automatic test_rv_write();
        int e;
        logic [7:0] exp [4];
        exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        run_rv(23'h066004, 32'hA1B2C3D4, 4'b1111, 1'b0, 0, 22'd0, 8'd0, e);
        n_tests++; if (e != 6) begin n_fail++; $display("FAIL wr_ack_latency got %0d edges want 6", e); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (mem[13'h004 + i] !== exp[i]) begin n_fail++; $display("FAIL wr_byte%0d got %h want %h", i, mem[13'h004 + i], exp[i]); end
        end
    endtask

    task automatic test_rv_read(input logic wrd, input logic [15:0] want);
        int e;
        run_rv(23'h066004, 32'd0, 4'b0000, wrd, 0, 22'd0, 8'd0, e);
        n_tests++; if (e != 5) begin n_fail++; $display("FAIL rd_ack_latency word=%0b got %0d edges want 5", wrd, e); end
        n_tests++; if (rv_dout !== want) begin n_fail++; $display("FAIL rd_dout word=%0b got %h want %h", wrd, rv_dout, want); end
    endtask

    task automatic test_reset_mid_read();
        int k;
        logic old_ack;
        rv_addr  = 23'h066004;
        rv_wstrb = 4'b0000;
        rv_word  = 1'b1;
        rv_req   = ~rv_ack;
        repeat (2) begin @(posedge clk); #1; end
        resetn = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (rv_ack !== 1'b0)   begin n_fail++; $display("FAIL midrst_ack got %b want 0", rv_ack); end
        n_tests++; if (rv_dout !== 16'd0) begin n_fail++; $display("FAIL midrst_dout got %h want 0000", rv_dout); end
        n_tests++; if (b_we !== 1'b0)     begin n_fail++; $display("FAIL midrst_we got %b want 0", b_we); end
        resetn  = 1'b1;
        old_ack = rv_ack;
        k = 0;
        while (rv_ack == old_ack && k < 30) begin @(posedge clk); #1; k++; end
        n_tests++; if (k != 5) begin n_fail++; $display("FAIL midrst_resume got %0d edges want 5", k); end
        n_tests++; if (rv_dout !== 16'hA1B2) begin n_fail++; $display("FAIL midrst_dout_after got %h want a1b2", rv_dout); end
    endtask

    task automatic test_cpu_stall();
        int e;
        int base;
        base = wr4_log.size();
        run_rv(23'h066004, 32'h11223344, 4'b1111, 1'b0, 1, 22'h006004, 8'h55, e);
        n_tests++; if (e != 7) begin n_fail++; $display("FAIL stall_ack_latency got %0d edges want 7", e); end
        n_tests++;
        if (wr4_log.size() != base + 2) begin
            n_fail++; $display("FAIL stall_wr_count got %0d want 2", wr4_log.size() - base);
        end else if (wr4_log[base] !== 8'h55 || wr4_log[base+1] !== 8'h44) begin
            n_fail++; $display("FAIL stall_wr_order got %h,%h want 55,44", wr4_log[base], wr4_log[base+1]);
        end
        n_tests++; if (mem[13'h004] !== 8'h44) begin n_fail++; $display("FAIL stall_final got %h want 44", mem[13'h004]); end
        n_tests++; if (mem[13'h007] !== 8'h11) begin n_fail++; $display("FAIL stall_lane3 got %h want 11", mem[13'h007]); end
    endtask

    task automatic test_load_priority();
        int e;
        load = 1'b1;
        run_rv(23'h066010, 32'h00000088, 4'b0001, 1'b0, 1, 22'h006010, 8'h77, e);
        load = 1'b0;
        n_tests++; if (e != 3) begin n_fail++; $display("FAIL load_ack_latency got %0d edges want 3", e); end
        n_tests++; if (mem[13'h010] !== 8'h88) begin n_fail++; $display("FAIL load_byte got %h want 88", mem[13'h010]); end
        n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL load_drop got %0d want 1", drop_cnt); end
    endtask

    task automatic test_non_hit();
        int   w0;
        logic old_ack;
        logic [7:0] m0;
        w0 = we_cnt;
        old_ack = rv_ack;
        rv_addr  = 23'h010000;
        rv_wstrb = 4'b1111;
        rv_wdata = 32'hDEADBEEF;
        #1;
        n_tests++; if (rv_sel !== 1'b0) begin n_fail++; $display("FAIL nonhit_sel got %b want 0", rv_sel); end
        rv_req = ~rv_ack;
        repeat (12) @(posedge clk);
        #1;
        n_tests++; if (rv_ack !== old_ack) begin n_fail++; $display("FAIL nonhit_ack got %b want %b", rv_ack, old_ack); end
        rv_req = rv_ack;
        #1;
        rv_addr = 23'h066004;
        m0 = mem[13'h000];
        cpu_addr = 22'h008000; cpu_wdata = 8'hEE; cpu_write = 1'b1;
        #1;
        n_tests++; if (cpu_hit !== 1'b0) begin n_fail++; $display("FAIL nonhit_cpu_hit got %b want 0", cpu_hit); end
        @(posedge clk); #1;
        cpu_write = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (we_cnt != w0) begin n_fail++; $display("FAIL nonhit_we got %0d writes want 0", we_cnt - w0); end
        n_tests++; if (mem[13'h000] !== m0) begin n_fail++; $display("FAIL nonhit_mem0 got %h want %h", mem[13'h000], m0); end
    endtask

    task automatic test_cpu_read_and_drop();
        cpu_addr = 22'h006006; cpu_read = 1'b1;
        @(posedge clk); #1;
        cpu_read = 1'b0;
        n_tests++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL cpu_rd_early got %h want 00", cpu_rdata); end
        @(posedge clk); #1;
        n_tests++; if (cpu_rdata !== 8'h22) begin n_fail++; $display("FAIL cpu_rd_data got %h want 22", cpu_rdata); end

        load = 1'b1;
        cpu_addr = 22'h006005; cpu_read = 1'b1;
        @(posedge clk); #1;
        cpu_read = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (cpu_rdata !== 8'h22) begin n_fail++; $display("FAIL drop_rd_hold got %h want 22", cpu_rdata); end
        n_tests++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL drop_rd_cnt got %0d want 2", drop_cnt); end

        cpu_wdata = 8'h99; cpu_write = 1'b1;
        @(posedge clk); #1;
        cpu_write = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (mem[13'h005] !== 8'h33) begin n_fail++; $display("FAIL drop_wr_mem got %h want 33", mem[13'h005]); end
        n_tests++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL drop_wr_cnt got %0d want 3", drop_cnt); end

        cpu_read = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        cpu_read = 1'b0;
        load = 1'b0;
        n_tests++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        resetn = 1'b0; load = 1'b0;
        cpu_addr = 22'h006000; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = 8'd0;
        rv_addr = 23'h066000; rv_word = 1'b0; rv_wdata = 32'd0; rv_wstrb = 4'd0; rv_req = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_rv_write();
        test_rv_read(1'b1, 16'hA1B2);
        test_reset_mid_read();
        test_rv_read(1'b0, 16'hC3D4);
        test_cpu_stall();
        test_load_priority();
        test_non_hit();
        test_cpu_read_and_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
